des_roteador: RTL and testbench
===============================

Name: des_roteador

Overview:
- 1-to-2 demultiplexing router, the receive-side counterpart of the 2:1 input router: one 4-bit input stream is steered to output A or output B according to SEL.
- Each destination has a 2-entry FIFO with a valid/ready handshake, so a stalled consumer does not corrupt traffic to the other output.
- Sits between a single producer and two independent consumers in the lab datapath.

Parameters:
- WIDTH, 4, data width in bits of the input and of both outputs.
- DEPTH, 2, entries per destination FIFO; fixed at 2 for this revision.

Ports:
- clock  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- Entrada  input  WIDTH  input data word.
- ent_valid  input  1  Entrada and SEL are valid this cycle.
- SEL  input  1  destination select: 0 routes to A, 1 routes to B.
- ent_ready  output  1  the word on Entrada is accepted this cycle.
- SaidaA  output  WIDTH  head word of FIFO A.
- a_valid  output  1  SaidaA holds a valid word.
- a_ready  input  1  consumer A takes the word.
- SaidaB  output  WIDTH  head word of FIFO B.
- b_valid  output  1  SaidaB holds a valid word.
- b_ready  input  1  consumer B takes the word.
- cnt_a  output  8  words accepted for A (STATS_EN only, otherwise 0).
- cnt_b  output  8  words accepted for B (STATS_EN only, otherwise 0).

Behaviour:
- Reset: asynchronous, active-high. Both FIFOs are emptied. a_valid=b_valid=0, SaidaA=SaidaB=0, cnt_a=cnt_b=0.
  - If reset asserts mid-transfer, all buffered words are discarded.
  - ent_ready=0 while reset is high.
- ent_ready is combinational: (SEL==0 ? !full_A : !full_B) && !reset.
  - Depends only on the selected FIFO. A full B never blocks a word destined for A.
- Push: occurs when ent_valid && ent_ready at a rising edge. Entrada is written into the FIFO selected by SEL.
- Pop: occurs when a_valid && a_ready (or b_valid && b_ready) at a rising edge. The head is removed.
- Latency: exactly 1 cycle from push to valid at the output. There is no combinational bypass, even when the FIFO is empty.
- Each FIFO is a 3-state occupancy machine:
  - EMPTY -> ONE on push.
  - ONE -> TWO on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE -> ONE on simultaneous push and pop.
  - TWO -> ONE on pop.
- Full rule: in TWO, ent_ready=0 for that destination even if a pop happens in the same cycle. There is no pop-through.
- Empty rule: pop is impossible because valid=0, so ready is ignored.
- Ordering is FIFO per destination. No ordering is guaranteed between A and B.
- SaidaX holds its head word stable while valid && !ready.
  - When empty, SaidaX holds its last value; the value is don't-care, and the bench must not check it.
- Pointers are 1-bit and wrap modulo DEPTH. Occupancy is a 2-bit count.
- ent_valid=0: SEL and Entrada are ignored.

Optional Feature:
- Macro: DES_ROTEADOR_STATS_EN.
- Defined:
  - cnt_a/cnt_b increment by 1 on each accepted push to A/B.
  - Counters saturate at 255 (no wrap) and clear on reset.
- Undefined:
  - No counter logic is synthesized. cnt_a and cnt_b are tied to 8'd0.
  - All other behaviour is identical.

Decomposition:
- Package des_roteador_pkg contains:
  - localparam WIDTH=4 and DEPTH=2.
  - typedef logic [WIDTH-1:0] dado_t.
  - typedef enum logic {DEST_A=1'b0, DEST_B=1'b1} destino_t.
  - typedef enum logic [1:0] {VAZIO, UM, CHEIO} ocup_t.
- Sub-module des_roteador_fifo: a 2-entry FIFO with push/pop/full/empty/head and async reset. It is instantiated twice (A and B). The top level holds the steering, the ready mux and the optional counters.

Test Plan:
- Reset mid-stream: push 4'h3 to A, assert reset before the pop -> a_valid=0, SaidaA=0 and cnt_a=0 immediately (asynchronously), with no clock needed.
- Basic steering: SEL=0 Entrada=4'hA, then SEL=1 Entrada=4'h5, with a_ready=b_ready=1 -> SaidaA=4'hA with a_valid one cycle after its push; SaidaB=4'h5 one cycle later; each valid pulses for one cycle.
- Fill A: a_ready=0, push 4'h1, 4'h2, 4'h3 with SEL=0 -> ent_ready=0 on the third push; SaidaA holds 4'h1. Then raise a_ready -> outputs 4'h1 then 4'h2 in order; 4'h3 is accepted only after the first pop.
- Independence: A full (a_ready=0), push 4'hC with SEL=1 -> ent_ready=1; SaidaB=4'hC with b_valid=1 next cycle.
- Simultaneous push/pop in state ONE: A holds 4'h7, a_ready=1, push 4'h8 with SEL=0 -> next cycle SaidaA=4'h8, a_valid=1, occupancy ONE.
- With DES_ROTEADOR_STATS_EN defined: 300 accepted pushes to B -> cnt_b=255 (saturated), cnt_a=0. Without the macro, both counters read 0 throughout.

Source files
------------

// File: rtl/des_roteador_pkg.sv
// Shared types and constants for the des_roteador 1-to-2 demultiplexing router.
package des_roteador_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 8;

  typedef logic [WIDTH-1:0] dado_t;

  typedef enum logic {
    DEST_A = 1'b0,
    DEST_B = 1'b1
  } destino_t;

  // Per-destination FIFO occupancy
  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    CHEIO = 2'd2
  } ocup_t;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/des_roteador_fifo.sv
// Two-entry FIFO with push/pop, full/valid flags and a registered head word.
// A push is refused internally when full, and a pop when empty, so callers
// cannot corrupt the occupancy count.
module des_roteador_fifo
  import des_roteador_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  logic  pop_i,
  input  dado_t dado_i,
  output dado_t head_o,
  output logic  valid_o,
  output logic  full_o
);

  ocup_t estado_q;
  logic  wr_q;
  logic  rd_q;
  dado_t mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign push_ok = push_i && (estado_q != CHEIO);
  assign pop_ok  = pop_i  && (estado_q != VAZIO);

  // Storage, 1-bit wrapping pointers and the occupancy state machine
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      estado_q <= VAZIO;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= dado_i;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) begin
        rd_q <= ~rd_q;
      end
      case (estado_q)
        VAZIO: begin
          if (push_ok) estado_q <= UM;
        end
        UM: begin
          if (push_ok && !pop_ok)      estado_q <= CHEIO;
          else if (pop_ok && !push_ok) estado_q <= VAZIO;
        end
        CHEIO: begin
          if (pop_ok) estado_q <= UM;
        end
        default: estado_q <= VAZIO;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign valid_o = (estado_q != VAZIO);
  assign full_o  = (estado_q == CHEIO);

endmodule

// File: rtl/des_roteador.sv
// des_roteador: steers one input stream into per-destination FIFOs A and B.
// Optional per-destination accepted-word counters: DES_ROTEADOR_STATS_EN.
module des_roteador
  import des_roteador_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] Entrada,
  input  logic             ent_valid,
  input  logic             SEL,
  output logic             ent_ready,
  output logic [WIDTH-1:0] SaidaA,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] SaidaB,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  destino_t dest;
  logic     full_a;
  logic     full_b;
  logic     push_a;
  logic     push_b;
  logic     aceito;

  assign dest = destino_t'(SEL);

  // Ready looks only at the selected FIFO; a full FIFO never accepts, even while popping
  assign ent_ready = ((dest == DEST_A) ? !full_a : !full_b) && !reset;
  assign aceito    = ent_valid && ent_ready;
  assign push_a    = aceito && (dest == DEST_A);
  assign push_b    = aceito && (dest == DEST_B);

  des_roteador_fifo u_fifo_a (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push_a),
    .pop_i   (a_ready),
    .dado_i  (Entrada),
    .head_o  (SaidaA),
    .valid_o (a_valid),
    .full_o  (full_a)
  );

  des_roteador_fifo u_fifo_b (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push_b),
    .pop_i   (b_ready),
    .dado_i  (Entrada),
    .head_o  (SaidaB),
    .valid_o (b_valid),
    .full_o  (full_b)
  );

`ifdef DES_ROTEADOR_STATS_EN
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;

  // Saturating counts of words accepted per destination
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (push_a) cnt_a_q <= sat_inc(cnt_a_q);
      if (push_b) cnt_b_q <= sat_inc(cnt_b_q);
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`else
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_des_roteador.sv
// Bench for des_roteador: directed scenarios plus random traffic, checked by
// a queue-based reference model sampled on the falling clock edge.
module tb_des_roteador;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] Entrada;
  logic       ent_valid;
  logic       SEL;
  logic       ent_ready;
  logic [3:0] SaidaA;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] SaidaB;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int         cnt_am = 0;
  int         cnt_bm = 0;

  des_roteador dut (
    .clock     (clock),
    .reset     (reset),
    .Entrada   (Entrada),
    .ent_valid (ent_valid),
    .SEL       (SEL),
    .ent_ready (ent_ready),
    .SaidaA    (SaidaA),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .SaidaB    (SaidaB),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cnt_exp(input int m);
`ifdef DES_ROTEADOR_STATS_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction

  // Reference model and monitor: inputs are stable here until the next rising edge
  always @(negedge clock) begin
    logic exp_rdy;
    if (reset) begin
      qa.delete();
      qb.delete();
      cnt_am = 0;
      cnt_bm = 0;
    end else begin
      check("a_valid", 32'(a_valid), 32'(qa.size() > 0));
      if (qa.size() > 0) check("SaidaA", 32'(SaidaA), 32'(qa[0]));
      check("b_valid", 32'(b_valid), 32'(qb.size() > 0));
      if (qb.size() > 0) check("SaidaB", 32'(SaidaB), 32'(qb[0]));
      exp_rdy = SEL ? (qb.size() < 2) : (qa.size() < 2);
      check("ent_ready", 32'(ent_ready), 32'(exp_rdy));
      check("cnt_a", 32'(cnt_a), 32'(cnt_exp(cnt_am)));
      check("cnt_b", 32'(cnt_b), 32'(cnt_exp(cnt_bm)));
      if (a_ready && qa.size() > 0) void'(qa.pop_front());
      if (b_ready && qb.size() > 0) void'(qb.pop_front());
      if (ent_valid && exp_rdy) begin
        if (SEL) begin
          qb.push_back(Entrada);
          if (cnt_bm < 255) cnt_bm++;
        end else begin
          qa.push_back(Entrada);
          if (cnt_am < 255) cnt_am++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic sel, input logic [3:0] d);
    ent_valid = 1'b1;
    SEL       = sel;
    Entrada   = d;
  endtask

  initial begin
    bit got;
    reset     = 1'b1;
    ent_valid = 1'b0;
    SEL       = 1'b0;
    Entrada   = 4'h0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;

    // Reset state
    #2;
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_SaidaA", 32'(SaidaA), 32'd0);
    check("rst_SaidaB", 32'(SaidaB), 32'd0);
    check("rst_ent_ready", 32'(ent_ready), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_cnt_b", 32'(cnt_b), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic steering
    a_ready = 1'b1;
    b_ready = 1'b1;
    push(1'b0, 4'hA);
    step();
    push(1'b1, 4'h5);
    step();
    ent_valid = 1'b0;
    repeat (3) step();

    // Fill A, then drain in order; 4'h3 waits for the first pop
    a_ready = 1'b0;
    push(1'b0, 4'h1);
    step();
    push(1'b0, 4'h2);
    step();
    push(1'b0, 4'h3);
    #1 check("fullA_ready", 32'(ent_ready), 32'd0);
    check("fullA_head", 32'(SaidaA), 32'h1);
    step();
    check("fullA_hold", 32'(SaidaA), 32'h1);
    a_ready = 1'b1;
    #1 check("no_pop_through", 32'(ent_ready), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ent_ready) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check("accept_3", 32'(got), 32'd1);
    step();
    ent_valid = 1'b0;
    repeat (4) step();

    // Independence: A full does not block B
    a_ready = 1'b0;
    push(1'b0, 4'h9);
    step();
    push(1'b0, 4'hE);
    step();
    push(1'b1, 4'hC);
    #1 check("indep_ready", 32'(ent_ready), 32'd1);
    step();
    ent_valid = 1'b0;
    check("indep_b_valid", 32'(b_valid), 32'd1);
    check("indep_SaidaB", 32'(SaidaB), 32'hC);
    a_ready = 1'b1;
    repeat (4) step();

    // Simultaneous push and pop while holding one word
    a_ready = 1'b0;
    push(1'b0, 4'h7);
    step();
    ent_valid = 1'b0;
    step();
    a_ready = 1'b1;
    push(1'b0, 4'h8);
    #1 check("simul_ready", 32'(ent_ready), 32'd1);
    step();
    ent_valid = 1'b0;
    a_ready   = 1'b0;
    check("simul_a_valid", 32'(a_valid), 32'd1);
    check("simul_SaidaA", 32'(SaidaA), 32'h8);
    step();
    a_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset while a word is buffered
    a_ready = 1'b0;
    push(1'b0, 4'h3);
    step();
    ent_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_a_valid", 32'(a_valid), 32'd0);
    check("mid_rst_SaidaA", 32'(SaidaA), 32'd0);
    check("mid_rst_cnt_a", 32'(cnt_a), 32'd0);
    check("mid_rst_ready", 32'(ent_ready), 32'd0);
    step();
    reset = 1'b0;

    // Counter saturation: 300 accepted pushes to B
    a_ready = 1'b1;
    b_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      push(1'b1, 4'($urandom));
      step();
    end
    ent_valid = 1'b0;
    step();
    check("sat_cnt_b", 32'(cnt_b), 32'(cnt_exp(255)));
    check("sat_cnt_a", 32'(cnt_a), 32'd0);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      ent_valid = 1'($urandom_range(0, 1));
      SEL       = 1'($urandom_range(0, 1));
      Entrada   = 4'($urandom);
      a_ready   = ($urandom_range(0, 9) < 6);
      b_ready   = ($urandom_range(0, 9) < 4);
      step();
    end

    ent_valid = 1'b0;
    a_ready   = 1'b1;
    b_ready   = 1'b1;
    repeat (5) step();
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
